// File: rtl/sb_3320_line_follower.sv
// Line-follower decision stage: thresholds and debounces three ADC readings,
// then drives a follow/node/search FSM that produces a registered turn command.
module sb_3320_line_follower #(
  parameter logic [11:0] THRESH       = 12'd1500,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_valid,
  input  logic [11:0] adc_left,
  input  logic [11:0] adc_center,
  input  logic [11:0] adc_right,
  output logic [2:0]  turn,
  output logic        node_pulse,
  output logic [7:0]  node_count,
  output logic        lost
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_NODE   = 3'd2,
    ST_SEARCH = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  localparam logic [2:0] TURN_STOP    = 3'b000;
  localparam logic [2:0] TURN_FWD     = 3'b001;
  localparam logic [2:0] TURN_LEFT    = 3'b010;
  localparam logic [2:0] TURN_RIGHT   = 3'b011;
  localparam logic [2:0] TURN_EXTREME = 3'b100;

  localparam int unsigned TW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(LOST_TIMEOUT - 1);
  localparam logic [3:0]    DEB_THR    = 4'(DEBOUNCE);

  function automatic logic [3:0] sat_inc4(input logic [3:0] c);
    if (c == 4'hF) begin
      return c;
    end else begin
      return c + 4'd1;
    end
  endfunction

  // Steering decode for non-node, non-empty patterns seen while following.
  function automatic logic [2:0] follow_turn(input logic [2:0] pat);
    case (pat)
      3'b010, 3'b101: return TURN_FWD;
      3'b110, 3'b100: return TURN_LEFT;
      3'b011, 3'b001: return TURN_RIGHT;
      default:        return TURN_STOP;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [2:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    stable_q, stable_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    turn_q, turn_d;
  logic          node_pulse_q, node_pulse_d;
  logic [7:0]    node_count_q, node_count_d;
  logic          lost_q, lost_d;

  logic [2:0]    samp_pat;
  logic [3:0]    cnt_next;

  // Threshold and debounce; independent of enable and FSM state.
  always_comb begin
    samp_pat = {adc_left > THRESH, adc_center > THRESH, adc_right > THRESH};
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    cnt_next = cnt_q;
    if (adc_valid) begin
      if (samp_pat == cand_q) begin
        cnt_next = sat_inc4(cnt_q);
      end else begin
        cand_d   = samp_pat;
        cnt_next = 4'd1;
      end
      cnt_d = cnt_next;
      if (cnt_next >= DEB_THR) begin
        stable_d = samp_pat;
      end else begin
        stable_d = stable_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM next state; outputs are computed for the edge that makes the transition.
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    turn_d       = TURN_STOP;
    node_pulse_d = 1'b0;
    node_count_d = node_count_q;
    lost_d       = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FOLLOW;
        end
        ST_FOLLOW: begin
          case (stable_q)
            3'b111: begin
              state_d      = ST_NODE;
              turn_d       = TURN_FWD;
              node_pulse_d = 1'b1;
              node_count_d = node_count_q + 8'd1;
            end
            3'b000: begin
              state_d = ST_SEARCH;
              turn_d  = TURN_EXTREME;
            end
            default: begin
              turn_d = follow_turn(stable_q);
            end
          endcase
        end
        ST_NODE: begin
          turn_d = TURN_FWD;
          if (stable_q != 3'b111) begin
            state_d = ST_FOLLOW;
          end else begin
            state_d = ST_NODE;
          end
        end
        ST_SEARCH: begin
          turn_d = TURN_EXTREME;
          // A reappearing line beats a timeout landing on the same cycle.
          if (stable_q != 3'b000) begin
            state_d = ST_FOLLOW;
          end else if (timer_q == TIMER_LAST) begin
            state_d = ST_HALT;
            turn_d  = TURN_STOP;
            lost_d  = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_HALT: begin
          lost_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_q       <= 3'b010;
      cnt_q        <= 4'd0;
      stable_q     <= 3'b010;
      timer_q      <= '0;
      turn_q       <= TURN_STOP;
      node_pulse_q <= 1'b0;
      node_count_q <= 8'd0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      timer_q      <= timer_d;
      turn_q       <= turn_d;
      node_pulse_q <= node_pulse_d;
      node_count_q <= node_count_d;
      lost_q       <= lost_d;
    end
  end

  assign turn       = turn_q;
  assign node_pulse = node_pulse_q;
  assign node_count = node_count_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_sb_3320_line_follower.sv
// Directed self-checking bench for sb_3320_line_follower (DEBOUNCE=3, LOST_TIMEOUT=20).
module tb_sb_3320_line_follower;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        enable;
  logic        adc_valid;
  logic [11:0] adc_left;
  logic [11:0] adc_center;
  logic [11:0] adc_right;
  logic [2:0]  turn;
  logic        node_pulse;
  logic [7:0]  node_count;
  logic        lost;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [11:0] LO = 12'd200;
  localparam logic [11:0] HI = 12'd3000;

  always #5 clk_50 = ~clk_50;

  sb_3320_line_follower #(
    .THRESH(12'd1500),
    .DEBOUNCE(3),
    .LOST_TIMEOUT(20)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .enable(enable),
    .adc_valid(adc_valid),
    .adc_left(adc_left),
    .adc_center(adc_center),
    .adc_right(adc_right),
    .turn(turn),
    .node_pulse(node_pulse),
    .node_count(node_count),
    .lost(lost)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic send(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    adc_valid  = 1'b1;
    adc_left   = l;
    adc_center = c;
    adc_right  = r;
    tick();
    adc_valid  = 1'b0;
  endtask

  task automatic send3(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    repeat (3) send(l, c, r);
  endtask

  // One full node visit starting and ending in FOLLOW.
  task automatic do_node();
    send3(HI, HI, HI);
    tick();
    send3(LO, HI, LO);
    tick();
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    adc_valid  = 1'b0;
    adc_left   = LO;
    adc_center = LO;
    adc_right  = LO;
    tick();
    tick();
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_pulse", 32'(node_pulse), 32'd0);
    check("rst_count", 32'(node_count), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_stable", 32'(dut.stable_q), 32'd2);
    reset = 1'b0;

    // Enable: FOLLOW after one edge, turn from stable (010) one edge later.
    enable = 1'b1;
    tick();
    check("en_idle_turn", 32'(turn), 32'd0);
    tick();
    check("en_follow_turn", 32'(turn), 32'd1);

    // Threshold boundary: 1501 is black, 1500 is white -> pattern 110.
    send(12'd1501, 12'd1501, 12'd1500);
    send(12'd1501, 12'd1501, 12'd1500);
    tick();
    check("deb_two_samples", 32'(turn), 32'd1);
    send(12'd1501, 12'd1501, 12'd1500);
    tick();
    check("left_turn", 32'(turn), 32'd2);

    // Single-sample glitch does not move the stable pattern.
    send(HI, LO, LO);
    tick();
    check("glitch_turn", 32'(turn), 32'd2);
    send3(LO, LO, HI);
    tick();
    check("right_turn", 32'(turn), 32'd3);

    // First node.
    send3(HI, HI, HI);
    tick();
    check("node_pulse_hi", 32'(node_pulse), 32'd1);
    check("node_count_1", 32'(node_count), 32'd1);
    check("node_turn", 32'(turn), 32'd1);
    tick();
    check("node_pulse_lo", 32'(node_pulse), 32'd0);
    send3(LO, HI, LO);
    tick();
    tick();
    check("node_exit_turn", 32'(turn), 32'd1);

    // Wrap of node_count.
    for (int i = 0; i < 254; i++) do_node();
    check("count_255", 32'(node_count), 32'd255);
    do_node();
    check("count_wrap", 32'(node_count), 32'd0);
    do_node();
    check("count_after_wrap", 32'(node_count), 32'd1);

    // Search timeout: 20 cycles of spin then HALT.
    send3(LO, LO, LO);
    tick();
    check("search_turn", 32'(turn), 32'd4);
    repeat (18) tick();
    tick();
    check("search_last_turn", 32'(turn), 32'd4);
    check("search_last_lost", 32'(lost), 32'd0);
    tick();
    check("halt_turn", 32'(turn), 32'd0);
    check("halt_lost", 32'(lost), 32'd1);

    // HALT ignores the line; only enable=0 leaves.
    send3(LO, HI, LO);
    tick();
    check("halt_sticky", 32'(lost), 32'd1);
    enable = 1'b0;
    tick();
    check("idle_lost", 32'(lost), 32'd0);
    check("idle_turn", 32'(turn), 32'd0);
    check("idle_count_kept", 32'(node_count), 32'd1);
    enable = 1'b1;
    tick();
    tick();
    check("refollow_turn", 32'(turn), 32'd1);

    // Line returns exactly as the timeout expires: FOLLOW wins.
    send3(LO, LO, LO);
    tick();
    repeat (16) tick();
    send3(LO, HI, LO);
    tick();
    check("race_lost", 32'(lost), 32'd0);
    check("race_turn_spin", 32'(turn), 32'd4);
    tick();
    check("race_follow_turn", 32'(turn), 32'd1);

    // Reset during SEARCH.
    send3(LO, LO, LO);
    tick();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("rs_search_turn", 32'(turn), 32'd0);
    check("rs_search_count", 32'(node_count), 32'd0);
    check("rs_search_stable", 32'(dut.stable_q), 32'd2);
    check("rs_search_timer", 32'(dut.timer_q), 32'd0);
    reset = 1'b0;

    // Reset during NODE.
    tick();
    send3(HI, HI, HI);
    tick();
    check("rs_node_pre_pulse", 32'(node_pulse), 32'd1);
    reset = 1'b1;
    tick();
    check("rs_node_pulse", 32'(node_pulse), 32'd0);
    check("rs_node_count", 32'(node_count), 32'd0);
    check("rs_node_turn", 32'(turn), 32'd0);
    check("rs_node_lost", 32'(lost), 32'd0);
    check("rs_node_stable", 32'(dut.stable_q), 32'd2);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_3320_line_follower.md
# sb_3320_line_follower

Decision stage that sits directly upstream of the motor-control block. It consumes the three line-sensor readings from the ADC front end, thresholds and debounces them, then runs a follow/node/search state machine. It emits the 3-bit turn command (stop/forward/left/right/extreme) that selects the motor PWM duty pattern, plus node-count and lost-line status for the path planner.

## Interface
- THRESH, 12'd1500: a reading strictly greater than this is black (on the line).
- DEBOUNCE, 3: consecutive identical accepted samples required before the stable pattern changes (range 1..15).
- LOST_TIMEOUT, 50_000_000: clk_50 cycles in SEARCH before giving up (1 s).
- clk_50  in  1  system clock, 50 MHz; the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- adc_valid  in  1  one-cycle strobe; the three readings are valid this cycle.
- adc_left  in  12  left sensor reading.
- adc_center  in  12  center sensor reading.
- adc_right  in  12  right sensor reading.
- turn  out  3  command: 000 stop, 001 forward, 010 left, 011 right, 100 extreme; 101–111 never driven.
- node_pulse  out  1  one-cycle pulse on entry to NODE.
- node_count  out  8  nodes seen since reset; wraps 255→0.
- lost  out  1  high in HALT.

## Operation
- Sampling (only on adc_valid=1):
  - p = {adc_left>THRESH, adc_center>THRESH, adc_right>THRESH}.
- Debounce registers: cand (3b), cnt (4b, saturating at 15), stable (3b).
  - If p==cand: cnt<=sat(cnt+1). Otherwise: cand<=p, cnt<=1.
  - If the resulting cnt ≥ DEBOUNCE: stable<=p, on the same edge.
  - Debounce runs regardless of enable or state.
- States: IDLE, FOLLOW, NODE, SEARCH, HALT.
  - IDLE: turn=000. If enable=1, go to FOLLOW.
  - FOLLOW: output from stable.
    - 010 or 101 → 001.
    - 110 or 100 → 010.
    - 011 or 001 → 011.
    - 111 → NODE.
    - 000 → SEARCH.
  - NODE: turn=001. On entry, node_pulse=1 for one cycle and node_count increments. Stay while stable==111; otherwise go to FOLLOW.
  - SEARCH: turn=100 (spin).
    - Timer increments every cycle from 0.
    - If stable≠000 → FOLLOW and the timer clears.
    - If the timer reaches LOST_TIMEOUT-1 with stable==000 → HALT.
  - HALT: turn=000, lost=1. Leaves only via enable=0 (→IDLE) or reset.
- Priority, highest first: reset > enable=0 (→IDLE from any state; lost clears, node_count retained) > state transitions.
- The SEARCH timer is held at 0 in all states except SEARCH.

## Timing
- Reset values:
  - Outputs: turn=000, node_pulse=0, node_count=0, lost=0.
  - Internal: state=IDLE, cand=010, cnt=0, stable=010, timer=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Latency:
  - stable updates on the edge that accepts the DEBOUNCE-th matching sample (edge N).
  - state, turn and node_pulse update on edge N+1.
  - With DEBOUNCE=1, an adc_valid at edge N gives the new turn at edge N+1.
- The FSM enters FOLLOW one edge after enable rises. turn then reflects the current stable pattern on the following edge, because FOLLOW output is evaluated in the FOLLOW state.
- Boundary cases:
  - A NODE→FOLLOW→NODE sequence counts two nodes.
  - node_count 255+1 → 0.
  - If the SEARCH timeout and a nonzero stable occur on the same cycle, FOLLOW wins.
  - enable=0 arriving on the same cycle as a timeout gives IDLE.
  - Reset mid-SEARCH clears the timer and all counters on that edge.
- adc_valid strobes closer together than 1 cycle are not possible. Back-to-back strobes (every cycle) are legal.

## Test plan
- Reset, then enable=1, then three samples L=C=R pattern {200,3000,200} with DEBOUNCE=3 → turn=001 one cycle after the 3rd strobe. No change after only 2 strobes.
- In FOLLOW, send 3× {3000,3000,200} → turn=010. Then 3× {200,200,3000} → turn=011. A single-sample glitch {3000,200,200} between them → turn unchanged.
- 3× {3000,3000,3000} → node_pulse high exactly 1 cycle, node_count 0→1, turn=001. Then 3× {200,3000,200} → FOLLOW. Repeat 256 nodes → node_count=0.
- 3× {200,200,200} with LOST_TIMEOUT=20 → turn=100 for 20 cycles, then turn=000, lost=1. A second case: a sample {200,3000,200}×3 landing on cycle 19 → FOLLOW, lost stays 0.
- In HALT, drop enable → IDLE, lost=0, node_count retained. Raise enable → FOLLOW.
- Assert reset during SEARCH and during NODE → next cycle all outputs at reset values, stable=010.
